// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB4 master. It turns a valid/ready
// command into an APB SETUP/ACCESS transfer and returns one registered
// response beat. A wait-state timeout aborts the transfer if the slave hangs.
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PADDR_SIZE = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    CLK,
  input  logic                    HRESET,
  // command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB master side
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_d;
  logic                  cmd_ready_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  rsp_err_d;
  logic                  rsp_timeout_d;
  logic                  psel_d;
  logic                  penable_d;
  logic                  pwrite_d;
  logic [PADDR_SIZE-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic [STRB_W-1:0]     pstrb_d;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    cmd_ready_d   = cmd_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d     = S_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          // reads drive a quiet data bus
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? cmd_strb  : '0;
        end
      end

      S_SETUP: begin
        state_d    = S_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end

      S_ACCESS: begin
        if (PREADY) begin
          // completion wins over a timeout on the same edge
          state_d       = S_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (wait_cnt == CNT_LAST) begin
          state_d       = S_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (HRESET) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
    end
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB4 master. It turns a simple valid/ready command interface into APB setup/access transfers that drive the GPIO APB slave's PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB. Each transfer ends in one registered response beat. A wait-state timeout guarantees that a hung slave cannot stall the requester.

## Interface
- DATA_WIDTH, 32, APB data width; multiple of 8
- PADDR_SIZE, 4, APB address width
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; must be ≥2
- CLK  in  1  clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  PADDR_SIZE  target register address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  PADDR_SIZE;  PWDATA  out  DATA_WIDTH;  PSTRB  out  DATA_WIDTH/8
- PREADY  in  1;  PRDATA  in  DATA_WIDTH;  PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs come from registers; there is no combinational path from input to output.
- IDLE: cmd_ready=1.
  - On cmd_valid & cmd_ready, latch the command, load PADDR/PWRITE/PWDATA/PSTRB, set PSEL=1 and PENABLE=0, and go to SETUP.
  - For reads, PWDATA=0 and PSTRB=0.
- SETUP: exactly one cycle. Set PENABLE=1, clear wait counter to 0, go to ACCESS.
- ACCESS: PSEL=PENABLE=1. PADDR, PWRITE, PWDATA and PSTRB stay stable.
  - PREADY=1 at an edge: capture rsp_rdata = PRDATA if read, else 0. Capture rsp_err=PSLVERR and rsp_timeout=0. Drop PSEL/PENABLE and go to RESP.
  - PREADY=0 and wait counter = TIMEOUT-1: abort. Drop PSEL/PENABLE; rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
  - Otherwise, increment the wait counter. The counter is $clog2(TIMEOUT) bits and never wraps.
  - PREADY=1 on the same edge the counter reaches TIMEOUT-1: PREADY wins and the transfer completes normally.
- RESP: rsp_valid=1, and response fields are held until rsp_valid & rsp_ready. On acceptance, clear rsp_valid and go to IDLE. cmd_ready=0 throughout RESP.
- Only one transfer is in flight. cmd_ready is 0 in SETUP, ACCESS and RESP.
- Reset has priority over every transition, including mid-ACCESS; the in-flight transfer is dropped with no response. Reset values:
  - state=IDLE, cmd_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0
  - wait counter=0
- Between transfers, PADDR/PWDATA/PSTRB hold their last values. PWRITE holds as well. PSEL=0 marks the bus idle.

## Timing
- Command accepted at edge E0: SETUP is visible in cycle E0+1 (PSEL=1, PENABLE=0) and ACCESS from E0+2.
- Zero-wait slave, PREADY=1 sampled at edge E2: rsp_valid=1 from E2+1. Latency from command acceptance to response is 3 cycles.
- Each PREADY-low ACCESS cycle adds 1 cycle of latency.
- Timeout: with PREADY stuck low, the abort occurs at the TIMEOUT-th ACCESS edge. rsp_valid rises TIMEOUT+2 cycles after acceptance.
- rsp_ready high in the first RESP cycle means the response is accepted at that edge. cmd_ready=1 the next cycle, so minimum spacing is 4 cycles per transfer.
- rsp_ready ignored outside RESP; cmd_valid ignored outside IDLE.

## Test plan
- Reset: hold HRESET high 3 cycles with cmd_valid=1 -> all outputs at reset values, no PSEL; after release, cmd_ready=1.
- Zero-wait write: addr=1, wdata=0xA5A5_0F0F, strb=0xF, PREADY tied 1 -> PSEL 2 cycles, PENABLE 1 cycle, PADDR/PWDATA stable; rsp_valid 3 cycles after accept with rsp_rdata=0, rsp_err=0.
- Wait-state read: addr=3, slave holds PREADY low 3 ACCESS cycles, then returns PRDATA=0x1234_5678 -> PSTRB=0, PWDATA=0, rsp_rdata=0x1234_5678, rsp_valid 6 cycles after accept.
- Slave error plus backpressure: PSLVERR=1 with PREADY, rsp_ready low 5 cycles -> rsp_err=1, rsp_timeout=0, response fields held, cmd_ready=0 until accepted, a pending cmd_valid not taken early.
- Timeout: TIMEOUT=16, PREADY stuck 0 -> exactly 16 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Separate case: PREADY=1 on the 16th ACCESS cycle -> normal completion.
- Reset mid-ACCESS: assert HRESET during the 2nd wait cycle -> next cycle PSEL=PENABLE=0, no rsp_valid; the following command completes normally.
